// File: rtl/vrf_pkg.sv
// Shared constants and types for the SIMD AES vector register file.
// Optional write-to-read forwarding is controlled by the VRF_BYPASS_EN macro.
package vrf_pkg;

  localparam int LANES_DEF = 16;
  localparam int W_DEF     = 8;
  localparam int NREGS_DEF = 16;

  typedef logic [W_DEF-1:0] lane_t;

  typedef enum logic {
    WM_NORMAL = 1'b0,
    WM_BCAST  = 1'b1
  } wmode_t;

endpackage

// File: rtl/vector_register_file_lane.sv
// One lane column of the vector register file: NREGS x W storage with two read muxes.
// Defining VRF_BYPASS_EN forwards this lane's pending write data to a matching read port.
module vrf_lane #(
  parameter int W     = 8,
  parameter int NREGS = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

`ifdef VRF_BYPASS_EN
  // Reset blocks forwarding so a discarded write never shows on a read port.
  logic fwd1, fwd2;

  always_comb begin
    fwd1 = we && !rst && (ra1 == wa);
    fwd2 = we && !rst && (ra2 == wa);
    rd1  = fwd1 ? wd : mem[ra1];
    rd2  = fwd2 ? wd : mem[ra2];
  end
`else
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
  end
`endif

endmodule

// File: rtl/vector_register_file.sv
// NREGS-entry array of LANES x W vector registers with masked/broadcast write and two reads.
// Build with VRF_BYPASS_EN defined to enable same-cycle write-to-read forwarding.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int W     = W_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               wmode,
  input  logic [AW-1:0]      wa,
  input  logic [LANES*W-1:0] wd,
  input  logic [LANES-1:0]   wmask,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  output logic [LANES*W-1:0] rd1,
  output logic [LANES*W-1:0] rd2
);

  wmode_t mode;
  assign mode = wmode_t'(wmode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] src;
    logic         lane_we;

    // Broadcast always sources lane 0, even when lane 0 itself is masked off.
    assign src     = (mode == WM_BCAST) ? wd[0 +: W] : wd[i*W +: W];
    assign lane_we = we & wmask[i];

    vrf_lane #(
      .W     (W),
      .NREGS (NREGS)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (lane_we),
      .wa  (wa),
      .wd  (src),
      .ra1 (ra1),
      .ra2 (ra2),
      .rd1 (rd1[i*W +: W]),
      .rd2 (rd2[i*W +: W])
    );
  end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed literal cases plus random traffic
// compared every cycle against an array model; VRF_BYPASS_EN selects the forwarding rule.
module tb_vector_register_file;

  localparam int LANES = 16;
  localparam int W     = 8;
  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);
  localparam int DW    = LANES * W;

  logic          clk = 1'b0;
  logic          rst, we, wmode;
  logic [AW-1:0] wa, ra1, ra2;
  logic [DW-1:0] wd, rd1, rd2;
  logic [LANES-1:0] wmask;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [W-1:0] model [NREGS][LANES];

  vector_register_file #(.LANES(LANES), .W(W), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wmode (wmode),
    .wa    (wa),
    .wd    (wd),
    .wmask (wmask),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  // Reference model: a plain 2-D array updated by the write rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++)
          model[r][l] <= '0;
    end else if (we) begin
      for (int l = 0; l < LANES; l++)
        if (wmask[l]) model[wa][l] <= wmode ? wd[0 +: W] : wd[l*W +: W];
    end
  end

  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) begin
      v[l*W +: W] = model[a][l];
`ifdef VRF_BYPASS_EN
      if (we && !rst && a == wa && wmask[l])
        v[l*W +: W] = wmode ? wd[0 +: W] : wd[l*W +: W];
`endif
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every falling edge: both read ports against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("rd1_model", rd1, expect_read(ra1));
      checkOutput("rd2_model", rd2, expect_read(ra2));
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic m, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [LANES-1:0] k);
    rst = r; we = w; wmode = m; wa = a; wd = d; wmask = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic readCheck(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    idle();
    ra1 = a;
    ra2 = a;
    #1;
    checkOutput({name, "_rd1"}, rd1, exp);
    checkOutput({name, "_rd2"}, rd2, exp);
  endtask

  initial begin
    logic [DW-1:0] exp_byp;
    ra1 = '0;
    ra2 = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check_en = 1'b1;
    tick();
    idle();
    readCheck("reset_r0", 0, '0);

    // Fill r3, then a single reset edge must clear everything.
    applyStimulus(1'b0, 1'b1, 1'b0, 3, {LANES{8'hAA}}, 16'hFFFF);
    tick();
    readCheck("pre_reset_r3", 3, {LANES{8'hAA}});
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    readCheck("reset_r3", 3, '0);
    for (int r = 0; r < NREGS; r++) readCheck("reset_all", AW'(r), '0);

    // Masked writes accumulate lanes.
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 128'h0F0E0D0C0B0A09080706050403020100, 16'h00FF);
    tick();
    readCheck("mask_lo", 5, 128'h0000000000000000_0706050403020100);
    applyStimulus(1'b0, 1'b1, 1'b0, 5, {DW{1'b1}}, 16'hFF00);
    tick();
    readCheck("mask_hi", 5, 128'hFFFFFFFFFFFFFFFF_0706050403020100);

    // Broadcast lane 0, including when lane 0 itself is masked.
    applyStimulus(1'b0, 1'b1, 1'b1, 2, {{15{8'h5C}}, 8'h63}, 16'hFFFF);
    tick();
    readCheck("bcast", 2, {LANES{8'h63}});
    applyStimulus(1'b0, 1'b1, 1'b1, 4, {{15{8'h11}}, 8'h5A}, 16'hFFFE);
    tick();
    readCheck("bcast_nolane0", 4, {{15{8'h5A}}, 8'h00});

    // Reset wins over a simultaneous write.
    applyStimulus(1'b0, 1'b1, 1'b0, 7, {LANES{8'h33}}, 16'hFFFF);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 7, {LANES{8'h11}}, 16'hFFFF);
    tick();
    readCheck("rst_prio_r7", 7, '0);
    readCheck("rst_prio_r5", 5, '0);

    // Same-cycle read of a register being written.
    applyStimulus(1'b0, 1'b1, 1'b0, 1, {LANES{8'h22}}, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1, {LANES{8'h44}}, 16'h000F);
    ra1 = 1;
    ra2 = 0;
`ifdef VRF_BYPASS_EN
    exp_byp = {{12{8'h22}}, {4{8'h44}}};
`else
    exp_byp = {LANES{8'h22}};
`endif
    #1;
    checkOutput("bypass_same_cycle", rd1, exp_byp);
    checkOutput("bypass_other_port", rd2, '0);
    tick();
    readCheck("bypass_after", 1, {{12{8'h22}}, {4{8'h44}}});

    // Dual read of one register, then a mask-zero write that must change nothing.
    applyStimulus(1'b0, 1'b1, 1'b0, 9, {LANES{8'hEE}}, 16'hFFFF);
    tick();
    readCheck("dual_r9", 9, {LANES{8'hEE}});
    applyStimulus(1'b0, 1'b1, 1'b0, 9, '0, '0);
    tick();
    readCheck("noop_r9", 9, {LANES{8'hEE}});

    // Random traffic, checked by the falling-edge compare process.
    for (int c = 0; c < 3000; c++) begin
      logic [LANES-1:0] k;
      logic [AW-1:0]    a;
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = '1;
        default: k = LANES'($urandom);
      endcase
      a = AW'($urandom);
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, k);
      ra1 = ($urandom_range(0, 2) == 0) ? a : AW'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? a : AW'($urandom);
      tick();
    end

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
